// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman packing path.
//   state_e     : packer control states (RUN accepts codewords, FLUSH drains)
//   len_width   : width of a field able to hold the values 0..n
//   msb_align   : left-aligns a right-justified codeword of len bits in width bits
//   B*_*        : prefix-code constants, right-justified, length given by the name
package huffman_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam logic [7:0] B2_0 = 8'b0000_0000;
  localparam logic [7:0] B2_1 = 8'b0000_0001;
  localparam logic [7:0] B3_0 = 8'b0000_0100;
  localparam logic [7:0] B3_1 = 8'b0000_0101;
  localparam logic [7:0] B4_0 = 8'b0000_1100;
  localparam logic [7:0] B4_1 = 8'b0000_1101;
  localparam logic [7:0] B6_0 = 8'b0011_1100;
  localparam logic [7:0] B8_0 = 8'b1111_1100;
  localparam logic [7:0] B8_1 = 8'b1111_1101;

  function automatic int len_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits of code above len are discarded before the shift; width and len must be <= 32.
  function automatic logic [31:0] msb_align(input logic [31:0] code,
                                            input int unsigned len,
                                            input int unsigned width);
    logic [31:0] m;
    if (len == 0) begin
      m = 32'd0;
    end else begin
      m = code & ((32'd1 << len) - 32'd1);
    end
    return m << (width - len);
  endfunction

endpackage

// File: rtl/huffman_pack_oreg.sv
// Single-entry valid/ready output register.
//   load               : capture d/fill/last (only asserted while free is high)
//   d, fill, last      : word, valid-bit count and final-word flag to capture
//   rdy_out            : downstream ready
//   d_out, fill_out,
//   last_out, en_out   : registered output word and its qualifiers
//   free               : slot can take a new word this cycle
module huffman_pack_oreg
  import huffman_pkg::*;
#(
  parameter int W_OUT = 8,
  parameter int FW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W_OUT-1:0] d,
  input  logic [FW-1:0]    fill,
  input  logic             last,
  input  logic             rdy_out,
  output logic [W_OUT-1:0] d_out,
  output logic [FW-1:0]    fill_out,
  output logic             last_out,
  output logic             en_out,
  output logic             free
);

  assign free = !en_out || rdy_out;

  // Output slot: load a new word, retire an accepted one, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      d_out    <= '0;
      fill_out <= '0;
      last_out <= 1'b0;
      en_out   <= 1'b0;
    end else if (load) begin
      d_out    <= d;
      fill_out <= fill;
      last_out <= last;
      en_out   <= 1'b1;
    end else if (rdy_out) begin
      en_out   <= 1'b0;
    end else begin
      en_out   <= en_out;
    end
  end

endmodule

// File: rtl/huffman_pack.sv
// Packs variable-length MSB-first codewords into W_OUT-bit words.
//   clk, rst          : clock, synchronous active-low reset
//   d_in, w_in        : codeword (left-aligned) and its length
//   en_in, rdy_in     : input handshake; flush_in rides the same handshake
//   d_out, fill_out   : packed word and its number of valid bits
//   en_out, rdy_out   : output handshake; last_out marks a padded final word
//   err_out           : sticky, a length above W_IN was received
//   busy_out          : data held in the accumulator or a flush in progress
module huffman_pack
  import huffman_pkg::*;
#(
  parameter int W_IN  = 8,
  parameter int W_OUT = 8,
  parameter int C     = $clog2(W_IN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W_IN-1:0]              d_in,
  input  logic [C-1:0]                 w_in,
  input  logic                         en_in,
  output logic                         rdy_in,
  input  logic                         flush_in,
  output logic [W_OUT-1:0]             d_out,
  output logic                         en_out,
  input  logic                         rdy_out,
  output logic                         last_out,
  output logic [$clog2(W_OUT+1)-1:0]   fill_out,
  output logic                         err_out,
  output logic                         busy_out
);

  localparam int ACC = W_OUT + 2 * W_IN;
  localparam int CW  = $clog2(ACC + 1);
  localparam int FW  = len_width(W_OUT);

  localparam logic [CW-1:0] W_OUT_C = CW'(W_OUT);
  localparam logic [CW-1:0] LIM_C   = CW'(ACC - W_IN);
  localparam logic [C-1:0]  W_IN_C  = C'(W_IN);

  state_e          state_r, state_nxt_s;
  logic [ACC-1:0]  acc_r, acc_nxt_s, acc_sh_s, place_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s, cnt_sh_s;
  logic            err_r, busy_r;
  logic            move_s, pad_s, take_s, app_s, flush_take_s, free_s;
  logic [W_IN-1:0] cw_s;
  logic [FW-1:0]   fill_s;

  // Accumulator invariant: all bits below the top cnt_r bits are zero, so the
  // top W_OUT bits are already zero-padded when a short final word is emitted.
  // Next-state, move/accept decisions and the append datapath.
  always_comb begin
    move_s       = 1'b0;
    pad_s        = 1'b0;
    acc_sh_s     = acc_r;
    cnt_sh_s     = cnt_r;
    fill_s       = FW'(W_OUT);
    state_nxt_s  = state_r;
    if (free_s && (cnt_r >= W_OUT_C)) begin
      move_s   = 1'b1;
      acc_sh_s = acc_r << W_OUT;
      cnt_sh_s = cnt_r - W_OUT_C;
    end else if (free_s && (state_r == FLUSH) && (cnt_r != '0)) begin
      pad_s    = 1'b1;
      acc_sh_s = '0;
      cnt_sh_s = '0;
      fill_s   = FW'(cnt_r);
    end else begin
      acc_sh_s = acc_r;
    end

    rdy_in       = (state_r == RUN) && (cnt_sh_s <= LIM_C);
    take_s       = en_in && rdy_in;
    flush_take_s = flush_in && rdy_in;
    app_s        = take_s && (w_in <= W_IN_C);

    // Keep only the top w_in bits of the codeword, then drop it in below cnt.
    cw_s    = d_in & ~({W_IN{1'b1}} >> w_in);
    place_s = {cw_s, {(ACC - W_IN){1'b0}}} >> cnt_sh_s;

    if (app_s) begin
      acc_nxt_s = acc_sh_s | place_s;
      cnt_nxt_s = cnt_sh_s + CW'(w_in);
    end else begin
      acc_nxt_s = acc_sh_s;
      cnt_nxt_s = cnt_sh_s;
    end

    // A flush that leaves nothing to drain never leaves RUN.
    case (state_r)
      RUN: begin
        if (flush_take_s && (cnt_nxt_s != '0)) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FLUSH: begin
        if (cnt_nxt_s == '0) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = FLUSH;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Accumulator, control state and status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= RUN;
      acc_r   <= '0;
      cnt_r   <= '0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_r || (take_s && (w_in > W_IN_C));
      busy_r  <= (state_nxt_s != RUN) || (cnt_nxt_s != '0);
    end
  end

  assign err_out  = err_r;
  assign busy_out = busy_r;

  huffman_pack_oreg #(
    .W_OUT (W_OUT),
    .FW    (FW)
  ) u_oreg (
    .clk      (clk),
    .rst      (rst),
    .load     (move_s || pad_s),
    .d        (acc_r[ACC-1 -: W_OUT]),
    .fill     (fill_s),
    .last     (pad_s),
    .rdy_out  (rdy_out),
    .d_out    (d_out),
    .fill_out (fill_out),
    .last_out (last_out),
    .en_out   (en_out),
    .free     (free_s)
  );

endmodule

// File: tb/tb_huffman_pack.sv
module tb_huffman_pack;
  import huffman_pkg::*;

  localparam int W_IN  = 8;
  localparam int W_OUT = 8;
  localparam int C     = $clog2(W_IN + 1);
  localparam int FW    = $clog2(W_OUT + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [W_IN-1:0]  d_in = '0;
  logic [C-1:0]     w_in = '0;
  logic             en_in = 1'b0, flush_in = 1'b0, rdy_out = 1'b1;
  logic             rdy_in, en_out, last_out, err_out, busy_out;
  logic [W_OUT-1:0] d_out;
  logic [FW-1:0]    fill_out;

  huffman_pack #(.W_IN(W_IN), .W_OUT(W_OUT), .C(C)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .w_in(w_in), .en_in(en_in),
    .rdy_in(rdy_in), .flush_in(flush_in), .d_out(d_out), .en_out(en_out),
    .rdy_out(rdy_out), .last_out(last_out), .fill_out(fill_out),
    .err_out(err_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss_cnt = 0;

  // Reference model: the accepted bit stream plus flush boundary positions.
  bit   mq[$];
  int   fq[$];
  int   total_in = 0, consumed = 0;
  bit   err_exp = 1'b0;
  bit   prev_hold = 1'b0;
  logic [W_OUT-1:0] prev_d;
  logic [FW-1:0]    prev_fill;
  logic             prev_last;
  logic [W_OUT-1:0] cap_d[$];
  logic [FW-1:0]    cap_fill[$];
  logic             cap_last[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expire(input string nm);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [W_OUT-1:0] ew;
    int lim, fl;
    bit lst, ok;
    if (!rst) begin
      mq.delete(); fq.delete();
      total_in = 0; consumed = 0; err_exp = 1'b0; prev_hold = 1'b0;
    end else begin
      chk("err_out", err_out, err_exp);
      if (prev_hold) begin
        chk("hold_en", en_out, 1);
        chk("hold_d", d_out, prev_d);
        chk("hold_fill", fill_out, prev_fill);
        chk("hold_last", last_out, prev_last);
      end
      if (en_out && rdy_out) begin
        cap_d.push_back(d_out); cap_fill.push_back(fill_out); cap_last.push_back(last_out);
        while (fq.size() > 0 && fq[0] == consumed) void'(fq.pop_front());
        lim = (fq.size() > 0) ? fq[0] - consumed : mq.size();
        ok = 1'b1; ew = '0; fl = 0; lst = 1'b0;
        if (lim >= W_OUT && mq.size() >= W_OUT) begin
          fl = W_OUT;
        end else if (fq.size() > 0 && lim > 0 && mq.size() >= lim) begin
          fl = lim; lst = 1'b1;
        end else begin
          ok = 1'b0;
        end
        for (int i = 0; i < fl; i++) begin
          ew[W_OUT-1-i] = mq.pop_front();
          consumed++;
        end
        if (lst) void'(fq.pop_front());
        chk("word_expected", ok, 1);
        chk("d_out", d_out, ew);
        chk("fill_out", fill_out, fl);
        chk("last_out", last_out, lst);
      end
      prev_hold = en_out && !rdy_out;
      prev_d = d_out; prev_fill = fill_out; prev_last = last_out;
      if (en_in && rdy_in) begin
        if (w_in > W_IN) begin
          err_exp = 1'b1;
        end else begin
          for (int i = 0; i < w_in; i++) mq.push_back(d_in[W_IN-1-i]);
          total_in += w_in;
        end
      end
      if (flush_in && rdy_in) fq.push_back(total_in);
    end
  end

  task automatic send(input logic [31:0] code, input int len, input bit fl);
    logic [31:0] a;
    bit ok;
    int g;
    if (len <= W_IN) a = msb_align(code, len, W_IN);
    else a = code;
    d_in = a[W_IN-1:0]; w_in = C'(len); en_in = 1'b1; flush_in = fl;
    ok = 1'b0; g = 0;
    while (!ok && g < 300) begin
      @(negedge clk); ok = rdy_in;
      @(posedge clk); #1; g++;
    end
    en_in = 1'b0; flush_in = 1'b0; d_in = '0; w_in = '0;
    if (!ok) expire("send_handshake");
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy_out || en_out) && g < 200) begin
      @(posedge clk); #1; g++;
    end
    if (busy_out || en_out) expire("wait_idle");
  endtask

  int n0;
  bit saw_low;
  logic [31:0] rc;
  int rl;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_d_out", d_out, 0); chk("rst_en_out", en_out, 0);
    chk("rst_last", last_out, 0); chk("rst_fill", fill_out, 0);
    chk("rst_err", err_out, 0); chk("rst_busy", busy_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: four 2-bit codewords -> 0x11, en_out one cycle after the last accept
    n0 = cap_d.size();
    send(B2_0, 2, 0); send(B2_1, 2, 0); send(B2_0, 2, 0); send(B2_1, 2, 0);
    @(posedge clk); #1;
    chk("t1_latency", en_out, 1);
    wait_idle();
    chk("t1_count", cap_d.size() - n0, 1);
    if (cap_d.size() > n0) begin
      chk("t1_word", cap_d[n0], 8'h11); chk("t1_fill", cap_fill[n0], 8);
    end

    // 2: eight alternating 3-bit codewords -> 0x96 0x59 0x65
    n0 = cap_d.size();
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? B3_0 : B3_1, 3, 0);
    wait_idle();
    chk("t2_count", cap_d.size() - n0, 3);
    if (cap_d.size() >= n0 + 3) begin
      chk("t2_w0", cap_d[n0], 8'h96); chk("t2_w1", cap_d[n0+1], 8'h59);
      chk("t2_w2", cap_d[n0+2], 8'h65);
    end
    chk("t2_busy", busy_out, 0);

    // 3: mixed lengths -> 0x34 0xFC 0xFD
    n0 = cap_d.size();
    send(B2_0, 2, 0); send(B4_1, 4, 0); send(B2_0, 2, 0);
    send(B8_0, 8, 0); send(B8_1, 8, 0);
    wait_idle();
    chk("t3_count", cap_d.size() - n0, 3);
    if (cap_d.size() >= n0 + 3) begin
      chk("t3_w0", cap_d[n0], 8'h34); chk("t3_w1", cap_d[n0+1], 8'hFC);
      chk("t3_w2", cap_d[n0+2], 8'hFD);
    end

    // 4: flush with a partial word, then a flush with nothing held
    n0 = cap_d.size();
    send(B6_0, 6, 1);
    wait_idle();
    chk("t4_count", cap_d.size() - n0, 1);
    if (cap_d.size() > n0) begin
      chk("t4_word", cap_d[n0], 8'hF0); chk("t4_fill", cap_fill[n0], 6);
      chk("t4_last", cap_last[n0], 1);
    end
    n0 = cap_d.size();
    send(32'd0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("t4_busy_idle", busy_out, 0);
      @(posedge clk); #1;
    end
    chk("t4_no_word", cap_d.size() - n0, 0);

    // 5: backpressure over 20 random codewords, then release and flush
    n0 = cap_d.size();
    saw_low = 1'b0;
    rdy_out = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rl = $urandom_range(1, 8);
          rc = $urandom & ((32'd1 << rl) - 32'd1);
          send(rc, rl, 0);
        end
        send(32'd0, 0, 1);
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (!rdy_in) saw_low = 1'b1;
        end
        chk("t5_stalled", cap_d.size() - n0, 0);
        @(posedge clk); #1;
        rdy_out = 1'b1;
      end
    join
    wait_idle();
    chk("t5_rdy_in_low", saw_low, 1);
    chk("t5_drained", mq.size(), 0);

    // 6: oversize length sets the sticky error and is dropped
    n0 = cap_d.size();
    send(32'h1FF, 9, 0);
    send(B2_0, 2, 0); send(B2_1, 2, 0); send(B2_0, 2, 0); send(B2_1, 2, 0);
    wait_idle();
    chk("t6_err", err_out, 1);
    chk("t6_count", cap_d.size() - n0, 1);
    if (cap_d.size() > n0) chk("t6_word", cap_d[n0], 8'h11);

    // 6b: reset with five bits held, then a clean stream
    send(B3_1, 3, 0); send(B2_1, 2, 0);
    chk("t6_busy_mid", busy_out, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_en", en_out, 0); chk("t6_rst_d", d_out, 0);
    chk("t6_rst_err", err_out, 0); chk("t6_rst_busy", busy_out, 0);
    chk("t6_rst_fill", fill_out, 0); chk("t6_rst_last", last_out, 0);
    rst = 1'b1;
    n0 = cap_d.size();
    send(B2_0, 2, 0); send(B2_1, 2, 0); send(B2_0, 2, 0); send(B2_1, 2, 0);
    wait_idle();
    chk("t6_clean_count", cap_d.size() - n0, 1);
    if (cap_d.size() > n0) chk("t6_clean_word", cap_d[n0], 8'h11);
    chk("end_model_empty", mq.size() + fq.size(), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/huffman_pack.md
Name: huffman_pack

Overview:
Parametrised successor to the Huffman encoder. It packs variable-length, MSB-first codewords into fixed W_OUT-bit output words. Input and output widths are independent. Both sides use valid/ready handshakes with full backpressure. A flush command closes a stream with a zero-padded final word, and out-of-range lengths raise a sticky error. It sits between the codeword generator and the byte/word stream writer in the compression path.

Parameters:
W_IN, 8, max codeword width; codeword is left-aligned in d_in
W_OUT, 8, packed output word width
C, $clog2(W_IN+1), width of the w_in length field
ACC (localparam), W_OUT+2*W_IN, accumulator bits
CW (localparam), $clog2(ACC+1), fill-counter width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low (clears state on the rising edge of clk while rst=0)
d_in  in  W_IN  codeword, MSB-aligned; bits below w_in are ignored
w_in  in  C  codeword length, 0..W_IN
en_in  in  1  input valid
rdy_in  out  1  input ready; transfer when en_in&&rdy_in
flush_in  in  1  end-of-stream request; takes effect under the same handshake as en_in
d_out  out  W_OUT  packed word; first-received bit at MSB
en_out  out  1  output valid
rdy_out  in  1  downstream ready; transfer when en_out&&rdy_out
last_out  out  1  qualifies the final word of a flushed stream
fill_out  out  $clog2(W_OUT+1)  valid bits in d_out; W_OUT except on a padded last word
err_out  out  1  sticky: a codeword with w_in>W_IN was seen
busy_out  out  1  state!=RUN or accumulator count!=0

Behaviour:
- Reset values: d_out=0, en_out=0, last_out=0, fill_out=0, err_out=0, busy_out=0, accumulator count=0, state=RUN. rst has priority over all other inputs; any partial word is discarded.
- Accumulator: ACC-bit shift register plus count cnt. An accepted codeword appends its top w_in bits directly below the existing cnt bits. cnt+=w_in.
- Output slot: a single register stage, free when !en_out || rdy_out.
- Move: when cnt>=W_OUT and the slot is free, the top W_OUT bits go to d_out. en_out=1, fill_out=W_OUT, last_out=0, cnt-=W_OUT. At most one move per cycle.
- rdy_in = (state==RUN) && (cnt - (move?W_OUT:0) <= ACC-W_IN). rdy_in is combinational on rdy_out. Move and accept in the same cycle are legal; the accumulator shifts, then appends.
- Latency: a codeword completing a word at cycle t yields en_out=1 at t+1. Sustained throughput is 1 codeword/cycle when rdy_out=1.
- w_in=0: handshake completes, no data change.
- w_in>W_IN: handshake completes, codeword dropped, err_out=1 until reset.
- en_out holds with d_out, fill_out and last_out stable until accepted.
- States:
  - RUN → FLUSH on accepted flush_in. If en_in and flush_in are both set, the codeword is appended first.
  - FLUSH: rdy_in=0. Continue full-word moves while cnt>=W_OUT. Then, if 0<cnt<W_OUT, emit the remaining bits MSB-aligned and zero-padded, with fill_out=cnt, last_out=1, cnt=0, and go to RUN. If cnt=0 when the flush is taken, do not emit a padded word; the most recent emitted word does not get last_out.
  - FLUSH → RUN once cnt=0 and the final word is loaded into the slot.
- busy_out falls only after the final word is loaded into the slot.

Decomposition:
- Package huffman_pkg:
  - MSB-alignment helper for codewords and length-width function.
  - State enum {RUN, FLUSH}.
  - Shared prefix-code constants for the encoder and its benches: B2_0=00, B2_1=01, B3_0=100, B3_1=101, B4_0=1100, B4_1=1101, B6_0=111100, B8_0=11111100, B8_1=11111101.
- Sub-module huffman_pack_oreg: the single-entry valid/ready output register, holding d_out, fill_out and last_out.
- The accumulator and FSM stay in the top level.

Test Plan:
1. W_IN=W_OUT=8. Codewords 00,01,00,01 (w=2), rdy_out=1 → one word 0x11, fill_out=8, en_out 1 cycle after the 4th accept.
2. Eight alternating 100/101 (w=3) → words 0x96, 0x59, 0x65 in order, with cnt=0 afterward.
3. Mixed: 00(w2), 1101(w4), 00(w2), then 11111100(w8), 11111101(w8) → 0x34, 0xFC, 0xFD.
4. Flush: 111100(w6), flush_in → 0xF0, fill_out=6, last_out=1. A further flush with cnt=0 → no output, busy_out stays 0.
5. Backpressure: rdy_out=0 while streaming 20 random codewords → rdy_in deasserts, d_out stable. After release, the output bitstream equals the reference concatenation with no loss or duplication.
6. Errors and reset: w_in=9 → err_out=1, codeword dropped, later words unaffected. rst=0 mid-word (cnt=5) → all outputs 0 next cycle, the next stream starts clean.
